// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants and types for the fetch queue controller
package fetch_pkg;

  localparam int LINE_BYTES = 8;
  localparam int LINE_BITS  = 8 * LINE_BYTES;
  localparam int OFFSET_W   = $clog2(LINE_BYTES);

  typedef enum logic {IDLE, RUN} fetch_state_e;

endpackage

// File: rtl/fetch_align.sv
// rtl/fetch_align.sv - drops the leading offset bytes of a fetched line and packs the rest
// MSB-first from index 0, zero-filled, with the resulting bit count.
module fetch_align #(
  parameter int LINE_BYTES = fetch_pkg::LINE_BYTES
) (
  input  logic [8*LINE_BYTES-1:0]       line,
  input  logic [$clog2(LINE_BYTES)-1:0] offset,
  output logic [8*LINE_BYTES-1:0]       data,
  output logic [31:0]                   cnt
);

  logic [7:0] byte_v;

  // Queue bit order is reversed within each byte: index 8k is the MSB of output byte k.
  always_comb begin
    data   = '0;
    byte_v = '0;
    for (int k = 0; k < LINE_BYTES; k++) begin
      if (k + int'(offset) < LINE_BYTES) begin
        byte_v = 8'(line >> (8 * (k + int'(offset))));
        for (int j = 0; j < 8; j++) data[8*k + j] = byte_v[7-j];
      end
    end
  end

  assign cnt = 32'(LINE_BYTES - int'(offset)) * 32'd8;

endmodule

// File: rtl/fetch_queue_ctrl.sv
// rtl/fetch_queue_ctrl.sv - issues line fetches ahead of the decoder under queue credit,
// enqueues returned lines, and flushes/drops stale traffic on redirect.
module fetch_queue_ctrl #(
  parameter int LINE_BYTES      = fetch_pkg::LINE_BYTES,
  parameter int MAX_OUTSTANDING = 2,
  parameter int ADDR_WIDTH      = 64,
  parameter int QUEUE_BITS      = 256
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    redirect,
  input  logic [ADDR_WIDTH-1:0]   redirect_addr,
  input  logic [31:0]             q_empty_cnt,
  output logic                    q_flush,
  output logic                    q_en_queue,
  output logic [31:0]             q_in_cnt,
  output logic [8*LINE_BYTES-1:0] q_in_data,
  output logic                    bus_req_valid,
  output logic [ADDR_WIDTH-1:0]   bus_req_addr,
  input  logic                    bus_req_ready,
  input  logic                    bus_resp_valid,
  input  logic [8*LINE_BYTES-1:0] bus_resp_data,
  output logic                    busy
);

  import fetch_pkg::*;

  localparam int LBITS = 8 * LINE_BYTES;
  localparam int OFF_W = $clog2(LINE_BYTES);
  localparam int CW    = $clog2(MAX_OUTSTANDING + 1);

  if (QUEUE_BITS < LBITS) begin : g_bad_cfg
    $error("QUEUE_BITS must be at least one line");
  end

  fetch_state_e          state;
  logic [CW-1:0]         inflight;
  logic [CW-1:0]         drop;
  logic [CW-1:0]         survivors;
  logic [OFF_W-1:0]      offset;
  logic [ADDR_WIDTH-1:0] fetch_addr;
  logic                  req_valid;
  logic                  accept;
  logic                  pending;
  logic                  issue;
  logic [31:0]           need;
  logic [LBITS-1:0]      align_data;
  logic [31:0]           align_cnt;

  fetch_align #(.LINE_BYTES(LINE_BYTES)) u_align (
    .line   (bus_resp_data),
    .offset (offset),
    .data   (align_data),
    .cnt    (align_cnt)
  );

  assign accept  = req_valid & bus_req_ready;
  assign pending = req_valid & ~bus_req_ready;

  // inflight counts every raised request, so a withdrawn one must be subtracted on redirect.
  assign survivors = inflight - CW'(pending) - CW'(bus_resp_valid);

  // Credit covers lines still owed to the queue, including one being enqueued this cycle.
  always_comb begin
    need  = (32'(inflight) - 32'(drop) + 32'd1) * 32'(LBITS);
    issue = (state == RUN) && !redirect && !pending &&
            (inflight < CW'(MAX_OUTSTANDING)) && (q_empty_cnt >= need);
  end

  assign q_flush       = redirect;
  assign q_en_queue    = bus_resp_valid && !redirect && (drop == '0);
  assign q_in_cnt      = q_en_queue ? align_cnt  : '0;
  assign q_in_data     = q_en_queue ? align_data : '0;
  assign bus_req_valid = req_valid;
  assign bus_req_addr  = fetch_addr;
  assign busy          = (inflight != '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      inflight   <= '0;
      drop       <= '0;
      offset     <= '0;
      fetch_addr <= '0;
      req_valid  <= 1'b0;
    end else if (redirect) begin
      state      <= RUN;
      fetch_addr <= {redirect_addr[ADDR_WIDTH-1:OFF_W], {OFF_W{1'b0}}};
      offset     <= redirect_addr[OFF_W-1:0];
      inflight   <= survivors;
      drop       <= survivors;
      req_valid  <= 1'b0;
    end else begin
      if (accept) fetch_addr <= fetch_addr + ADDR_WIDTH'(LINE_BYTES);
      req_valid <= issue | pending;
      inflight  <= inflight + CW'(issue) - CW'(bus_resp_valid);
      if (bus_resp_valid) begin
        if (drop != '0) drop   <= drop - CW'(1);
        else            offset <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      assert (!redirect) else $fatal(1, "redirect during reset");
    end else begin
      assert (!(bus_resp_valid && inflight == '0)) else $fatal(1, "response with nothing in flight");
      assert (!(q_en_queue && q_in_cnt > q_empty_cnt)) else $fatal(1, "enqueue exceeds queue space");
    end
  end

endmodule

// File: tb/tb_fetch_queue_ctrl.sv
// tb/tb_fetch_queue_ctrl.sv - directed-vector bench for fetch_queue_ctrl
module tb_fetch_queue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect;
  logic [63:0] redirect_addr;
  logic [31:0] q_empty_cnt;
  logic        q_flush;
  logic        q_en_queue;
  logic [31:0] q_in_cnt;
  logic [63:0] q_in_data;
  logic        bus_req_valid;
  logic [63:0] bus_req_addr;
  logic        bus_req_ready;
  logic        bus_resp_valid;
  logic [63:0] bus_resp_data;
  logic        busy;

  int          n_vec = 0;
  int          n_err = 0;
  int          cyc   = 0;
  int          lat   = 2;
  logic [63:0] pend_addr[$];
  int          pend_due[$];
  logic        seen;

  // Reversed-byte images of the lines used below (index 0 = MSB of first kept byte).
  localparam logic [63:0] LINE_00_FULL = 64'hE060A020C0408000;
  localparam logic [63:0] LINE_08_FULL = 64'hF070B030D0509010;
  localparam logic [63:0] LINE_00_OFF3 = 64'h000000E060A020C0;
  localparam logic [63:0] LINE_F8_OFF7 = 64'h00000000000000FF;

  fetch_queue_ctrl dut (
    .clk            (clk),
    .reset          (reset),
    .redirect       (redirect),
    .redirect_addr  (redirect_addr),
    .q_empty_cnt    (q_empty_cnt),
    .q_flush        (q_flush),
    .q_en_queue     (q_en_queue),
    .q_in_cnt       (q_in_cnt),
    .q_in_data      (q_in_data),
    .bus_req_valid  (bus_req_valid),
    .bus_req_addr   (bus_req_addr),
    .bus_req_ready  (bus_req_ready),
    .bus_resp_valid (bus_resp_valid),
    .bus_resp_data  (bus_resp_data),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] line_of(input logic [63:0] a);
    logic [63:0] l;
    for (int i = 0; i < 8; i++) l[8*i +: 8] = a[7:0] + 8'(i);
    return l;
  endfunction

  task automatic tick();
    if (!reset && bus_req_valid && bus_req_ready) begin
      pend_addr.push_back(bus_req_addr);
      pend_due.push_back(cyc + lat);
    end
    @(posedge clk);
    #1;
    cyc++;
    redirect = 1'b0;
    if (reset) begin
      pend_addr.delete();
      pend_due.delete();
    end
    bus_resp_valid = 1'b0;
    bus_resp_data  = '0;
    if (pend_due.size() > 0 && pend_due[0] == cyc) begin
      bus_resp_valid = 1'b1;
      bus_resp_data  = line_of(pend_addr[0]);
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    reset         = 1'b1;
    redirect      = 1'b0;
    bus_req_ready = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic redir(input string tag, input logic [63:0] a);
    redirect      = 1'b1;
    redirect_addr = a;
    #1;
    check_val(tag, 64'(q_flush), 64'd1);
    tick();
  endtask

  task automatic chk_enq(input string tag, input logic [31:0] cnt, input logic [63:0] data);
    check_val({tag, "_en"},   64'(q_en_queue), 64'd1);
    check_val({tag, "_cnt"},  64'(q_in_cnt),   64'(cnt));
    check_val({tag, "_data"}, q_in_data,       data);
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [63:0] a);
    check_val({tag, "_valid"}, 64'(bus_req_valid), 64'(v));
    if (v) check_val({tag, "_addr"}, bus_req_addr, a);
  endtask

  initial begin
    reset          = 1'b1;
    redirect       = 1'b0;
    redirect_addr  = '0;
    q_empty_cnt    = 32'd256;
    bus_req_ready  = 1'b1;
    bus_resp_valid = 1'b0;
    bus_resp_data  = '0;

    // Reset state, then a full-line stream with two requests in flight.
    do_reset();
    check_val("rst_valid", 64'(bus_req_valid), 64'd0);
    check_val("rst_addr",  bus_req_addr,       64'd0);
    check_val("rst_en",    64'(q_en_queue),    64'd0);
    check_val("rst_cnt",   64'(q_in_cnt),      64'd0);
    check_val("rst_busy",  64'(busy),          64'd0);
    check_val("rst_flush", 64'(q_flush),       64'd0);
    tick();
    chk_req("idle", 1'b0, '0);
    lat = 2;
    redir("t1_flush", 64'h1000);
    chk_req("t1_c1", 1'b0, '0);
    tick(); chk_req("t1_c2", 1'b1, 64'h1000);
    tick(); chk_req("t1_c3", 1'b1, 64'h1008);
    tick(); chk_req("t1_c4", 1'b0, '0);
    chk_enq("t1_r0", 32'd64, LINE_00_FULL);
    check_val("t1_busy", 64'(busy), 64'd1);
    tick(); chk_req("t1_c5", 1'b0, '0);
    chk_enq("t1_r1", 32'd64, LINE_08_FULL);
    tick(); chk_req("t1_c6", 1'b1, 64'h1010);
    tick(); chk_req("t1_c7", 1'b1, 64'h1018);

    // Reset with two in flight and a request held pending.
    bus_req_ready = 1'b0;
    reset = 1'b1;
    tick();
    check_val("t6_valid", 64'(bus_req_valid), 64'd0);
    check_val("t6_addr",  bus_req_addr,       64'd0);
    check_val("t6_en",    64'(q_en_queue),    64'd0);
    check_val("t6_cnt",   64'(q_in_cnt),      64'd0);
    check_val("t6_data",  q_in_data,          64'd0);
    check_val("t6_busy",  64'(busy),          64'd0);
    reset = 1'b0;
    bus_req_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (bus_req_valid) seen = 1'b1;
    end
    check_val("t6_no_req", 64'(seen), 64'd0);

    // Misaligned redirect: first line trimmed to 5 bytes.
    do_reset();
    lat = 2;
    redir("t2_flush", 64'h1003);
    tick(); chk_req("t2_c2", 1'b1, 64'h1000);
    tick_n(2);
    chk_enq("t2_r0", 32'd40, LINE_00_OFF3);
    tick();
    chk_enq("t2_r1", 32'd64, LINE_08_FULL);

    // Credit limit: 100 free bits allow only one line outstanding.
    do_reset();
    q_empty_cnt = 32'd100;
    redir("t3_flush", 64'h3000);
    tick(); chk_req("t3_c2", 1'b1, 64'h3000);
    tick(); chk_req("t3_c3", 1'b0, '0);
    tick();
    chk_enq("t3_r0", 32'd64, LINE_00_FULL);
    tick(); chk_req("t3_c5", 1'b0, '0);
    tick(); chk_req("t3_c6", 1'b1, 64'h3008);
    do_reset();
    q_empty_cnt = 32'd63;
    redir("t3b_flush", 64'h3000);
    seen = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (bus_req_valid) seen = 1'b1;
      tick();
    end
    check_val("t3b_no_req", 64'(seen), 64'd0);
    check_val("t3b_busy",   64'(busy), 64'd0);

    // Redirect with two requests in flight: both responses dropped.
    do_reset();
    q_empty_cnt = 32'd256;
    lat = 3;
    redir("t4_flush0", 64'h1000);
    tick_n(3);
    chk_req("t4_c4", 1'b0, '0);
    check_val("t4_busy", 64'(busy), 64'd1);
    redir("t4_flush", 64'h2000);
    check_val("t4_drop0", 64'(q_en_queue), 64'd0);
    chk_req("t4_c5", 1'b0, '0);
    tick();
    check_val("t4_drop1", 64'(q_en_queue), 64'd0);
    chk_req("t4_c6", 1'b0, '0);
    tick(); chk_req("t4_c7", 1'b1, 64'h2000);
    tick_n(3);
    chk_enq("t4_r", 32'd64, LINE_00_FULL);

    // Redirect coinciding with an accept and a response.
    do_reset();
    lat = 2;
    redir("t5_flush0", 64'h1000);
    tick();
    tick(); chk_req("t5_c3", 1'b1, 64'h1008);
    bus_req_ready = 1'b0;
    tick(); chk_req("t5_c4", 1'b1, 64'h1008);
    bus_req_ready = 1'b1;
    redirect      = 1'b1;
    redirect_addr = 64'h4000;
    #1;
    check_val("t5_flush", 64'(q_flush),    64'd1);
    check_val("t5_en_t",  64'(q_en_queue), 64'd0);
    tick(); chk_req("t5_c5", 1'b0, '0);
    tick();
    check_val("t5_drop", 64'(q_en_queue), 64'd0);
    chk_req("t5_c6", 1'b1, 64'h4000);
    tick();
    check_val("t5_quiet", 64'(q_en_queue), 64'd0);
    tick();
    chk_enq("t5_r", 32'd64, LINE_00_FULL);

    // Top-of-memory redirect: single byte kept, next address wraps to 0.
    do_reset();
    lat = 2;
    redir("t7_flush", 64'hFFFF_FFFF_FFFF_FFFF);
    tick(); chk_req("t7_c2", 1'b1, 64'hFFFF_FFFF_FFFF_FFF8);
    tick(); chk_req("t7_c3", 1'b1, 64'h0);
    tick();
    chk_enq("t7_r0", 32'd8, LINE_F8_OFF7);
    tick();
    chk_enq("t7_r1", 32'd64, LINE_00_FULL);

    do_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
